// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle RV32I control unit: FSM states, ALU op classes,
// datapath mux selects and the opcodes the decoder recognises.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    StFetch    = 4'd0,
    StDecode   = 4'd1,
    StMemAdr   = 4'd2,
    StMemRead  = 4'd3,
    StMemWb    = 4'd4,
    StMemWrite = 4'd5,
    StExecR    = 4'd6,
    StAluWb    = 4'd7,
    StExecI    = 4'd8,
    StJal      = 4'd9,
    StBranch   = 4'd10,
    StFault    = 4'd11
  } state_e;

  typedef enum logic [1:0] {
    AluOpAdd   = 2'b00,
    AluOpSub   = 2'b01,
    AluOpFunct = 2'b10
  } alu_op_e;

  localparam logic [2:0] AluCtlAdd = 3'b000;
  localparam logic [2:0] AluCtlSub = 3'b001;
  localparam logic [2:0] AluCtlAnd = 3'b010;
  localparam logic [2:0] AluCtlOr  = 3'b011;
  localparam logic [2:0] AluCtlSlt = 3'b101;

  localparam logic [1:0] ResAluOut    = 2'b00;
  localparam logic [1:0] ResData      = 2'b01;
  localparam logic [1:0] ResAluResult = 2'b10;

  localparam logic [1:0] SrcAPc    = 2'b00;
  localparam logic [1:0] SrcAOldPc = 2'b01;
  localparam logic [1:0] SrcARegA  = 2'b10;

  localparam logic [1:0] SrcBWd   = 2'b00;
  localparam logic [1:0] SrcBImm  = 2'b01;
  localparam logic [1:0] SrcBFour = 2'b10;

  localparam logic [1:0] ImmI = 2'b00;
  localparam logic [1:0] ImmS = 2'b01;
  localparam logic [1:0] ImmB = 2'b10;
  localparam logic [1:0] ImmJ = 2'b11;

  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpRtype  = 7'b0110011;
  localparam logic [6:0] OpItype  = 7'b0010011;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpBranch = 7'b1100011;

endpackage

// File: rtl/mc_alu_decoder.sv
// ALU decoder: maps the FSM's ALU op class plus instruction function fields to an ALU
// control code.
module mc_alu_decoder
  import mc_ctrl_pkg::*;
(
  input  alu_op_e    alu_op,
  input  logic [2:0] funct3,
  input  logic       op_b5,
  input  logic       funct7b5,
  output logic [2:0] alu_control
);

  always_comb begin
    alu_control = AluCtlAdd;
    case (alu_op)
      AluOpSub: alu_control = AluCtlSub;
      AluOpFunct: begin
        case (funct3)
          // I-type has op[5]=0, so funct7b5 (an immediate bit there) never selects sub
          3'b000:  alu_control = (op_b5 & funct7b5) ? AluCtlSub : AluCtlAdd;
          3'b010:  alu_control = AluCtlSlt;
          3'b110:  alu_control = AluCtlOr;
          3'b111:  alu_control = AluCtlAnd;
          default: alu_control = AluCtlAdd;
        endcase
      end
      default: alu_control = AluCtlAdd;
    endcase
  end

endmodule

// File: rtl/mc_control_unit.sv
// Multicycle RV32I control unit: Moore FSM driving the shared-memory datapath, immediate
// select decoder and a sticky fault flag for unsupported encodings.
module mc_control_unit
  import mc_ctrl_pkg::*;
#(
  parameter bit FAULT_HALT = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       Zero,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] ResultSrc,
  output logic [2:0] ALUControl,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ImmSrc,
  output logic       RegWrite,
  output logic       fault,
  output logic [3:0] state_dbg
);

  state_e  state_q, state_d, out_state;
  logic    fault_q;
  alu_op_e alu_op;
  logic    pc_update, branch, ir_write, mem_write, reg_write;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= StFetch;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_d == StFault) fault_q <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StFetch: state_d = StDecode;
      StDecode: begin
        if (op == OpLoad || op == OpStore)                  state_d = StMemAdr;
        else if (op == OpRtype)                             state_d = StExecR;
        else if (op == OpItype)                             state_d = StExecI;
        else if (op == OpJal)                               state_d = StJal;
        else if (op == OpBranch && funct3[2:1] == 2'b00)    state_d = StBranch;
        else                                                state_d = FAULT_HALT ? StFault : StFetch;
      end
      StMemAdr:   state_d = op[5] ? StMemWrite : StMemRead;
      StMemRead:  state_d = StMemWb;
      StMemWb:    state_d = StFetch;
      StMemWrite: state_d = StFetch;
      StExecR:    state_d = StAluWb;
      StExecI:    state_d = StAluWb;
      StAluWb:    state_d = StFetch;
      StJal:      state_d = StAluWb;
      StBranch:   state_d = StFetch;
      StFault:    state_d = StFault;
      default:    state_d = StFetch;
    endcase
  end

  // Outputs decode as FETCH while reset is held so the datapath sees a clean fetch setup.
  assign out_state = reset ? state_q : StFetch;

  always_comb begin
    AdrSrc    = 1'b0;
    ResultSrc = ResAluOut;
    ALUSrcA   = SrcAPc;
    ALUSrcB   = SrcBWd;
    alu_op    = AluOpAdd;
    pc_update = 1'b0;
    branch    = 1'b0;
    ir_write  = 1'b0;
    mem_write = 1'b0;
    reg_write = 1'b0;
    case (out_state)
      StFetch: begin
        ir_write  = 1'b1;
        ALUSrcB   = SrcBFour;
        ResultSrc = ResAluResult;
        pc_update = 1'b1;
      end
      StDecode: begin
        ALUSrcA = SrcAOldPc;
        ALUSrcB = SrcBImm;
      end
      StMemAdr: begin
        ALUSrcA = SrcARegA;
        ALUSrcB = SrcBImm;
      end
      StMemRead: AdrSrc = 1'b1;
      StMemWb: begin
        ResultSrc = ResData;
        reg_write = 1'b1;
      end
      StMemWrite: begin
        AdrSrc    = 1'b1;
        mem_write = 1'b1;
      end
      StExecR: begin
        ALUSrcA = SrcARegA;
        alu_op  = AluOpFunct;
      end
      StExecI: begin
        ALUSrcA = SrcARegA;
        ALUSrcB = SrcBImm;
        alu_op  = AluOpFunct;
      end
      StAluWb: reg_write = 1'b1;
      StJal: begin
        ALUSrcA   = SrcAOldPc;
        ALUSrcB   = SrcBFour;
        pc_update = 1'b1;
      end
      StBranch: begin
        ALUSrcA = SrcARegA;
        alu_op  = AluOpSub;
        branch  = 1'b1;
      end
      default: ;
    endcase
  end

  // funct3[0] distinguishes bne from beq
  assign PCWrite  = reset & (pc_update | (branch & (Zero ^ funct3[0])));
  assign IRWrite  = reset & ir_write;
  assign MemWrite = reset & mem_write;
  assign RegWrite = reset & reg_write;

  always_comb begin
    case (op)
      OpStore:  ImmSrc = ImmS;
      OpBranch: ImmSrc = ImmB;
      OpJal:    ImmSrc = ImmJ;
      default:  ImmSrc = ImmI;
    endcase
  end

  mc_alu_decoder u_alu_decoder (
    .alu_op      (alu_op),
    .funct3      (funct3),
    .op_b5       (op[5]),
    .funct7b5    (funct7b5),
    .alu_control (ALUControl)
  );

  assign fault     = fault_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_mc_control_unit.sv
// Directed bench for mc_control_unit: one halting and one non-halting instance share stimulus.
module tb_mc_control_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       Zero;

  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, fault;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
  logic [2:0] ALUControl;
  logic [3:0] state_dbg;

  logic       nh_PCWrite, nh_AdrSrc, nh_MemWrite, nh_IRWrite, nh_RegWrite, nh_fault;
  logic [1:0] nh_ResultSrc, nh_ALUSrcA, nh_ALUSrcB, nh_ImmSrc;
  logic [2:0] nh_ALUControl;
  logic [3:0] nh_state_dbg;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  mc_control_unit #(.FAULT_HALT(1'b1)) dut (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5), .Zero(Zero),
    .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .ResultSrc(ResultSrc), .ALUControl(ALUControl), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ImmSrc(ImmSrc), .RegWrite(RegWrite), .fault(fault), .state_dbg(state_dbg)
  );

  mc_control_unit #(.FAULT_HALT(1'b0)) dut_nh (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5), .Zero(Zero),
    .PCWrite(nh_PCWrite), .AdrSrc(nh_AdrSrc), .MemWrite(nh_MemWrite), .IRWrite(nh_IRWrite),
    .ResultSrc(nh_ResultSrc), .ALUControl(nh_ALUControl), .ALUSrcA(nh_ALUSrcA),
    .ALUSrcB(nh_ALUSrcB), .ImmSrc(nh_ImmSrc), .RegWrite(nh_RegWrite), .fault(nh_fault),
    .state_dbg(nh_state_dbg)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; op = 7'd0; funct3 = 3'd0; funct7b5 = 1'b0; Zero = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_checks++;
      if (state_dbg !== 4'd0) $display("FAIL reset state: got %0d want 0", state_dbg);
      else n_pass++;
      n_checks++;
      if (IRWrite !== 1'b0 || PCWrite !== 1'b0)
        $display("FAIL reset enables: got IRWrite=%b PCWrite=%b want 0 0", IRWrite, PCWrite);
      else n_pass++;
    end
    reset = 1'b1;
    #1;
    n_checks++;
    if (IRWrite !== 1'b1) $display("FAIL release IRWrite: got %b want 1", IRWrite);
    else n_pass++;
    n_checks++;
    if (fault !== 1'b0 || nh_fault !== 1'b0)
      $display("FAIL release fault: got %b/%b want 0/0", fault, nh_fault);
    else n_pass++;
    n_checks++;
    if (ALUSrcB !== 2'b10 || ResultSrc !== 2'b10 || AdrSrc !== 1'b0)
      $display("FAIL fetch selects: got B=%b Res=%b Adr=%b want 10 10 0",
               ALUSrcB, ResultSrc, AdrSrc);
    else n_pass++;
  endtask

  task automatic test_rtype();
    int exp_st [5];
    logic [2:0] f3_v [2];
    logic [2:0] ctl_v [2];
    exp_st = '{0, 1, 6, 7, 0};
    f3_v = '{3'b000, 3'b010};
    ctl_v = '{3'b001, 3'b101};
    for (int k = 0; k < 2; k++) begin
      op = 7'b0110011; funct3 = f3_v[k]; funct7b5 = 1'b1;
      for (int i = 0; i < 5; i++) begin
        if (i > 0) tick();
        n_checks++;
        if (state_dbg !== exp_st[i][3:0])
          $display("FAIL rtype%0d state[%0d]: got %0d want %0d", k, i, state_dbg, exp_st[i]);
        else n_pass++;
        n_checks++;
        if (RegWrite !== (i == 3))
          $display("FAIL rtype%0d RegWrite[%0d]: got %b want %b", k, i, RegWrite, i == 3);
        else n_pass++;
        if (i == 2) begin
          n_checks++;
          if (ALUControl !== ctl_v[k] || ALUSrcA !== 2'b10 || ALUSrcB !== 2'b00)
            $display("FAIL rtype%0d exec: got ctl=%b A=%b B=%b want %b 10 00",
                     k, ALUControl, ALUSrcA, ALUSrcB, ctl_v[k]);
          else n_pass++;
        end
      end
    end
  endtask

  task automatic test_itype();
    int exp_st [5];
    logic [2:0] f3_v [2];
    logic [2:0] ctl_v [2];
    exp_st = '{0, 1, 8, 7, 0};
    f3_v = '{3'b000, 3'b110};
    ctl_v = '{3'b000, 3'b011};
    for (int k = 0; k < 2; k++) begin
      op = 7'b0010011; funct3 = f3_v[k]; funct7b5 = 1'b1;
      for (int i = 0; i < 5; i++) begin
        if (i > 0) tick();
        n_checks++;
        if (state_dbg !== exp_st[i][3:0])
          $display("FAIL itype%0d state[%0d]: got %0d want %0d", k, i, state_dbg, exp_st[i]);
        else n_pass++;
        if (i == 2) begin
          n_checks++;
          if (ALUControl !== ctl_v[k] || ALUSrcB !== 2'b01)
            $display("FAIL itype%0d exec: got ctl=%b B=%b want %b 01",
                     k, ALUControl, ALUSrcB, ctl_v[k]);
          else n_pass++;
        end
      end
    end
  endtask

  task automatic test_load_store();
    int exp_lw [6];
    int exp_sw [5];
    int mw_cycles;
    exp_lw = '{0, 1, 2, 3, 4, 0};
    exp_sw = '{0, 1, 2, 5, 0};
    op = 7'b0000011; funct3 = 3'b010; funct7b5 = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) tick();
      n_checks++;
      if (state_dbg !== exp_lw[i][3:0])
        $display("FAIL lw state[%0d]: got %0d want %0d", i, state_dbg, exp_lw[i]);
      else n_pass++;
      n_checks++;
      if (AdrSrc !== (i == 3)) $display("FAIL lw AdrSrc[%0d]: got %b want %b", i, AdrSrc, i == 3);
      else n_pass++;
      if (i == 4) begin
        n_checks++;
        if (ResultSrc !== 2'b01 || RegWrite !== 1'b1)
          $display("FAIL lw writeback: got Res=%b RegWrite=%b want 01 1", ResultSrc, RegWrite);
        else n_pass++;
      end
      // opcode changes after MEMADR must not disturb the sequence
      if (i == 3) op = 7'b1111111;
    end
    op = 7'b0100011; funct3 = 3'b010;
    mw_cycles = 0;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) tick();
      n_checks++;
      if (state_dbg !== exp_sw[i][3:0])
        $display("FAIL sw state[%0d]: got %0d want %0d", i, state_dbg, exp_sw[i]);
      else n_pass++;
      if (MemWrite === 1'b1) mw_cycles++;
      if (i == 1) begin
        n_checks++;
        if (ImmSrc !== 2'b01) $display("FAIL sw ImmSrc: got %b want 01", ImmSrc);
        else n_pass++;
      end
    end
    n_checks++;
    if (mw_cycles != 1) $display("FAIL sw MemWrite cycles: got %0d want 1", mw_cycles);
    else n_pass++;
  endtask

  task automatic test_branch();
    int exp_st [4];
    logic [2:0] f3_v [3];
    logic       z_v  [3];
    logic       pcw_v [3];
    exp_st = '{0, 1, 10, 0};
    f3_v = '{3'b000, 3'b001, 3'b001};
    z_v = '{1'b1, 1'b1, 1'b0};
    pcw_v = '{1'b1, 1'b0, 1'b1};
    for (int k = 0; k < 3; k++) begin
      op = 7'b1100011; funct3 = f3_v[k]; Zero = z_v[k];
      for (int i = 0; i < 4; i++) begin
        if (i > 0) tick();
        n_checks++;
        if (state_dbg !== exp_st[i][3:0])
          $display("FAIL br%0d state[%0d]: got %0d want %0d", k, i, state_dbg, exp_st[i]);
        else n_pass++;
        if (i == 2) begin
          n_checks++;
          if (PCWrite !== pcw_v[k])
            $display("FAIL br%0d PCWrite: got %b want %b", k, PCWrite, pcw_v[k]);
          else n_pass++;
          n_checks++;
          if (ALUControl !== 3'b001 || ImmSrc !== 2'b10)
            $display("FAIL br%0d ctl/imm: got %b/%b want 001/10", k, ALUControl, ImmSrc);
          else n_pass++;
        end
      end
    end
    Zero = 1'b0;
  endtask

  task automatic test_jal();
    int exp_st [5];
    exp_st = '{0, 1, 9, 7, 0};
    op = 7'b1101111; funct3 = 3'b000;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) tick();
      n_checks++;
      if (state_dbg !== exp_st[i][3:0])
        $display("FAIL jal state[%0d]: got %0d want %0d", i, state_dbg, exp_st[i]);
      else n_pass++;
      if (i == 1) begin
        n_checks++;
        if (ImmSrc !== 2'b11) $display("FAIL jal ImmSrc: got %b want 11", ImmSrc);
        else n_pass++;
      end
      if (i == 2) begin
        n_checks++;
        if (PCWrite !== 1'b1 || ALUSrcA !== 2'b01 || ALUSrcB !== 2'b10)
          $display("FAIL jal exec: got PCW=%b A=%b B=%b want 1 01 10", PCWrite, ALUSrcA, ALUSrcB);
        else n_pass++;
      end
      n_checks++;
      if (RegWrite !== (i == 3)) $display("FAIL jal RegWrite[%0d]: got %b want %b", i, RegWrite, i == 3);
      else n_pass++;
    end
  endtask

  task automatic test_fault();
    op = 7'b0110111; funct3 = 3'b000;
    tick();
    n_checks++;
    if (state_dbg !== 4'd1 || nh_state_dbg !== 4'd1 || fault !== 1'b0)
      $display("FAIL fault decode: got %0d/%0d fault=%b want 1/1 0", state_dbg, nh_state_dbg, fault);
    else n_pass++;
    tick();
    n_checks++;
    if (state_dbg !== 4'd11 || fault !== 1'b1)
      $display("FAIL fault entry: got %0d fault=%b want 11 1", state_dbg, fault);
    else n_pass++;
    n_checks++;
    if (nh_state_dbg !== 4'd0 || nh_fault !== 1'b0)
      $display("FAIL nohalt retire: got %0d fault=%b want 0 0", nh_state_dbg, nh_fault);
    else n_pass++;
    for (int i = 0; i < 10; i++) begin
      tick();
      n_checks++;
      if (state_dbg !== 4'd11 || fault !== 1'b1 ||
          {PCWrite, MemWrite, IRWrite, RegWrite} !== 4'b0000)
        $display("FAIL fault hold[%0d]: got st=%0d fault=%b en=%b want 11 1 0000", i, state_dbg,
                 fault, {PCWrite, MemWrite, IRWrite, RegWrite});
      else n_pass++;
      n_checks++;
      if (nh_fault !== 1'b0) $display("FAIL nohalt fault[%0d]: got %b want 0", i, nh_fault);
      else n_pass++;
    end
    reset = 1'b0;
    tick();
    n_checks++;
    if (state_dbg !== 4'd0 || fault !== 1'b0 || IRWrite !== 1'b0 || nh_state_dbg !== 4'd0)
      $display("FAIL fault clear: got st=%0d fault=%b IRW=%b nh=%0d want 0 0 0 0", state_dbg, fault,
               IRWrite, nh_state_dbg);
    else n_pass++;
    reset = 1'b1;
    op = 7'd0;
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_itype();
    test_load_store();
    test_branch();
    test_jal();
    test_fault();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mc_control_unit.md
Name: mc_control_unit

Overview:
- Control unit for the multicycle RV32I core. Drives the shared-memory datapath: PC, IR, OldPC, Data, A/WriteData and ALUOut registers, plus the single-ported instruction/data memory.
- Holds the main Moore FSM, ALU decoder and immediate-select decoder. Emits per-cycle mux selects and write enables.
- Supports lw, sw, R-type (add/sub/and/or/slt), I-type ALU, beq, bne and jal. Unsupported encodings go to a sticky fault state.

Parameters:
- FAULT_HALT, 1, 1: unsupported instruction latches fault and halts. 0: instruction retires as a NOP (returns to FETCH).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-low.
- op  in  7  Instr[6:0].
- funct3  in  3  Instr[14:12].
- funct7b5  in  1  Instr[30].
- Zero  in  1  ALU zero flag.
- PCWrite  out  1  PC register enable.
- AdrSrc  out  1  memory address: 0=PC, 1=Result.
- MemWrite  out  1  memory write enable.
- IRWrite  out  1  IR/OldPC enable.
- ResultSrc  out  2  00=ALUOut, 01=Data, 10=ALUResult.
- ALUControl  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt.
- ALUSrcA  out  2  00=PC, 01=OldPC, 10=A.
- ALUSrcB  out  2  00=WriteData, 01=ImmExt, 10=const 4.
- ImmSrc  out  2  00 I, 01 S, 10 B, 11 J.
- RegWrite  out  1  register file write enable.
- fault  out  1  sticky unsupported-instruction flag.
- state_dbg  out  4  current state encoding, for the bench.

Behaviour:
- States and encodings: FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECR 6, ALUWB 7, EXECI 8, JAL 9, BRANCH 10, FAULT 11.
- Reset: at a clk edge with reset=0, state<=FETCH and fault<=0. While reset=0, PCWrite, MemWrite, IRWrite and RegWrite are forced to 0 combinationally. All other outputs follow FETCH decode.
- Moore outputs (unlisted signals are 0 / 00; ALUOp is internal: 00 add, 01 sub, 10 funct):
  - FETCH: AdrSrc0, IRWrite1, SrcA00, SrcB10, ALUOp00, ResultSrc10, PCUpdate1.
  - DECODE: SrcA01, SrcB01, ALUOp00.
  - MEMADR: SrcA10, SrcB01, ALUOp00.
  - MEMREAD: ResultSrc00, AdrSrc1.
  - MEMWB: ResultSrc01, RegWrite1.
  - MEMWRITE: ResultSrc00, AdrSrc1, MemWrite1.
  - EXECR: SrcA10, SrcB00, ALUOp10.
  - EXECI: SrcA10, SrcB01, ALUOp10.
  - ALUWB: ResultSrc00, RegWrite1.
  - JAL: SrcA01, SrcB10, ALUOp00, ResultSrc00, PCUpdate1.
  - BRANCH: SrcA10, SrcB00, ALUOp01, ResultSrc00, Branch1.
  - FAULT: all enables 0.
- PCWrite = PCUpdate | (Branch & (Zero ^ funct3[0])).
- Transitions:
  - FETCH->DECODE.
  - DECODE by op:
    - 0000011 or 0100011 -> MEMADR.
    - 0110011 -> EXECR.
    - 0010011 -> EXECI.
    - 1101111 -> JAL.
    - 1100011 with funct3 000/001 -> BRANCH.
    - Anything else -> FAULT (FAULT_HALT=1) or FETCH (FAULT_HALT=0).
  - MEMADR -> MEMREAD if op[5]=0, else MEMWRITE.
  - MEMREAD->MEMWB->FETCH.
  - MEMWRITE->FETCH.
  - EXECR/EXECI->ALUWB->FETCH.
  - JAL->ALUWB.
  - BRANCH->FETCH.
  - FAULT->FAULT until reset.
- fault: set on the edge that enters FAULT, held until reset.
- Cycle counts: lw 5, sw 4, R/I 4, jal 4, branch 3.
- ALU decoder:
  - ALUOp00 -> add; ALUOp01 -> sub.
  - ALUOp10 by funct3:
    - 000: sub iff op[5]&funct7b5, else add.
    - 010: slt.
    - 110: or.
    - 111: and.
    - Any other funct3: add.
- ImmSrc is combinational from op:
  - 0100011 -> 01.
  - 1100011 -> 10.
  - 1101111 -> 11.
  - Else 00.
- Decode inputs are sampled only in DECODE and MEMADR; op/funct changes in other states do not affect transitions.

Decomposition:
- Package mc_ctrl_pkg: state enum, ALUOp, ALUControl, ResultSrc/ALUSrcA/ALUSrcB/ImmSrc encodings, opcode constants.
- Sub-module mc_alu_decoder (ALUOp, funct3, op[5], funct7b5 -> ALUControl).
- FSM and ImmSrc decoder live in mc_control_unit.

Test Plan:
- Reset low 2 cycles, then high -> state_dbg=0, IRWrite=0 while reset low, IRWrite=1 in the first cycle after release, fault=0.
- op=0110011, funct3=000, funct7b5=1 (sub, 0x405203B3) -> states 0,1,6,7,0; ALUControl=001 in EXECR; RegWrite=1 only in ALUWB.
- lw (op 0000011) -> states 0,1,2,3,4,0; AdrSrc=1 in MEMREAD; ResultSrc=01 with RegWrite=1 in MEMWB. sw (op 0100011) -> 0,1,2,5,0 with MemWrite=1 for exactly one cycle, ImmSrc=01.
- beq with Zero=1 -> PCWrite=1 in BRANCH. bne (funct3=001) with Zero=1 -> PCWrite=0. bne with Zero=0 -> PCWrite=1.
- jal (op 1101111) -> 0,1,9,7,0; PCWrite=1 in JAL; ImmSrc=11; RegWrite in ALUWB.
- op=0110111 with FAULT_HALT=1 -> FAULT, fault=1, no enables for 10 cycles; reset low clears it. With FAULT_HALT=0 -> DECODE->FETCH, fault stays 0.
